// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: stream output buffer depth and pointer-width helper.
package fifo_pkg;

  localparam int unsigned STREAM_BUF_DEPTH = 2;

  // Pointer/occupancy width able to represent 0..depth inclusive.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return unsigned'($clog2(depth)) + 32'd1;
  endfunction

  localparam int unsigned OCC_WIDTH = ptr_width(STREAM_BUF_DEPTH);

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered buffer. Entry 0 is the head; a read shifts entry 1 forward.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail_nxt;
  logic [OCC_WIDTH-1:0]  occ_nxt;

  // Next contents: pop shifts tail forward, write lands in the first free slot after the pop.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    occ_nxt  = occ;
    if (rd_en) begin
      head_nxt = tail;
      occ_nxt  = occ - OCC_WIDTH'(1);
    end
    if (wr_en) begin
      if ((occ == '0) || (rd_en && (occ == OCC_WIDTH'(1)))) begin
        head_nxt = wr_data;
      end else begin
        tail_nxt = wr_data;
      end
      occ_nxt = occ_nxt + OCC_WIDTH'(1);
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      occ  <= occ_nxt;
    end
  end

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side adapter from fifo_generic to a valid/ready stream.
// Optional beat counter (word_count port) enabled by FIFO_READ_STREAM_CNT_EN.
module fifo_read_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_READ_STREAM_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READ_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);

  localparam int unsigned LOAD_WIDTH = OCC_WIDTH + 1;

  logic                  pending;
  logic                  pop_c;
  logic                  capture_c;
  logic [OCC_WIDTH-1:0]  occ;
  logic [LOAD_WIDTH-1:0] load_c;

  // Words owned after this edge: buffered plus in flight, minus the one leaving now.
  assign pop_c     = clk_enable & m_valid & m_ready;
  assign capture_c = clk_enable & pending;
  assign load_c    = LOAD_WIDTH'(occ) + LOAD_WIDTH'(pending) - LOAD_WIDTH'(pop_c);

  // Issue a pop only when a buffer slot is guaranteed for the returning word;
  // gated by reset_n so the strobe drops the moment reset asserts.
  assign fifo_read = reset_n & clk_enable & ~fifo_empty &
                     (load_c < LOAD_WIDTH'(STREAM_BUF_DEPTH));

  assign m_valid = (occ != '0);

  // Tracks the one-cycle FIFO read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (clk_enable) begin
      pending <= fifo_read;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (capture_c),
    .wr_data (fifo_read_data),
    .rd_en   (pop_c),
    .occ     (occ),
    .head    (m_data)
  );

`ifdef FIFO_READ_STREAM_CNT_EN
  // Counts accepted output beats, wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
    end else if (pop_c) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO with registered read data,
// scoreboard of delivered beats against the words written into the FIFO.
module tb_fifo_read_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_enable;
  logic          fifo_empty;
  logic          fifo_read;
  logic [DW-1:0] fifo_read_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_READ_STREAM_CNT_EN
  logic [CW-1:0] word_count;
`endif

  fifo_read_stream #(
    .DATA_WIDTH (DW)
`ifdef FIFO_READ_STREAM_CNT_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_enable     (clk_enable),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .fifo_read_data (fifo_read_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data)
`ifdef FIFO_READ_STREAM_CNT_EN
    ,
    .word_count     (word_count)
`endif
  );

  initial forever #5 clk = ~clk;

  // Behavioural FIFO: wr_ptr owned by the stimulus, rd_ptr by the pop process.
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (clk_enable && fifo_read && !fifo_empty) begin
      fifo_read_data <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted beats and protocol violations.
  logic [DW-1:0] got_data [0:1023];
  int            got_cyc  [0:1023];
  int            got_n = 0;
  int            rd_pulses = 0;
  int            inflight = 0;
  int            viol_rd = 0;
  int            viol_stable = 0;
  int            viol_over = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (fifo_read && (fifo_empty || !clk_enable)) viol_rd <= viol_rd + 1;
    if (!reset_n) begin
      inflight  <= 0;
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && (!m_valid || (m_data !== prev_data))) viol_stable <= viol_stable + 1;
      prev_hold <= m_valid && !(m_ready && clk_enable);
      prev_data <= m_data;
      if (clk_enable && fifo_read) rd_pulses <= rd_pulses + 1;
      if (clk_enable && m_valid && m_ready) begin
        got_data[got_n] <= m_data;
        got_cyc[got_n]  <= cyc;
        got_n           <= got_n + 1;
      end
      if (inflight + int'(clk_enable && fifo_read) - int'(clk_enable && m_valid && m_ready) > 2)
        viol_over <= viol_over + 1;
      inflight <= inflight + int'(clk_enable && fifo_read) - int'(clk_enable && m_valid && m_ready);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_base = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_got(input int target, input int budget, input string name);
    int t;
    t = 0;
    while ((got_n < target) && (t < budget)) begin
      tick();
      t++;
    end
    n_checks++;
    if (got_n < target) $display("FAIL %s_timeout got %0d beats want %0d", name, got_n, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    clk_enable = 1'b1;
    m_ready    = 1'b0;
    repeat (2) tick();
    push(8'h5A);
    #1;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else n_pass++;
    n_checks++; if (fifo_read !== 1'b0) $display("FAIL reset_fifo_read got %b want 0", fifo_read); else n_pass++;
`ifdef FIFO_READ_STREAM_CNT_EN
    n_checks++; if (word_count !== '0) $display("FAIL reset_word_count got %0d want 0", word_count); else n_pass++;
`endif
    wr_ptr = rd_ptr;
    tick();
    reset_n  = 1'b1;
    cnt_base = got_n;
    tick();
  endtask

  task automatic test_basic();
    int base, n0;
    logic [DW-1:0] w [0:2];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    m_ready = 1'b1;
    base = got_n;
    n0   = cyc;
    for (int i = 0; i < 3; i++) push(w[i]);
    #1;
    n_checks++; if (fifo_read !== 1'b1) $display("FAIL basic_read_same_cycle got %b want 1", fifo_read); else n_pass++;
    wait_got(base + 3, 20, "basic");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_data[base+i] !== w[i]) $display("FAIL basic_data%0d got %h want %h", i, got_data[base+i], w[i]);
      else n_pass++;
      n_checks++;
      if (got_cyc[base+i] !== n0 + 2 + i) $display("FAIL basic_cycle%0d got %0d want %0d", i, got_cyc[base+i] - n0, 2 + i);
      else n_pass++;
    end
    tick();
`ifdef FIFO_READ_STREAM_CNT_EN
    n_checks++; if (word_count !== CW'(3)) $display("FAIL basic_word_count got %0d want 3", word_count); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    int base, rp;
    logic [DW-1:0] w [0:7];
    m_ready = 1'b0;
    base = got_n;
    rp   = rd_pulses;
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom);
      push(w[i]);
    end
    repeat (12) tick();
    n_checks++; if (rd_pulses - rp !== 2) $display("FAIL bp_read_pulses got %0d want 2", rd_pulses - rp); else n_pass++;
    n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== w[0]) $display("FAIL bp_head got %h want %h", m_data, w[0]); else n_pass++;
    n_checks++; if (got_n !== base) $display("FAIL bp_no_beats got %0d want %0d", got_n - base, 0); else n_pass++;
    m_ready = 1'b1;
    wait_got(base + 8, 30, "bp");
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_data[base+i] !== w[i]) $display("FAIL bp_data%0d got %h want %h", i, got_data[base+i], w[i]);
      else n_pass++;
    end
    n_checks++;
    if (got_cyc[base+7] - got_cyc[base] !== 7)
      $display("FAIL bp_no_bubble got span %0d want 7", got_cyc[base+7] - got_cyc[base]);
    else n_pass++;
  endtask

  task automatic test_toggle();
    int base, k;
    logic [DW-1:0] w [0:127];
    logic [DW-1:0] d;
    base = got_n;
    k    = 0;
    for (int c = 0; c < 60; c++) begin
      if (c < 30) m_ready = ((c % 2) == 0);
      else        m_ready = 1'($urandom_range(0, 1));
      if ((c < 30 && (wr_ptr - rd_ptr) < 3) || (c >= 30 && $urandom_range(0, 2) == 0)) begin
        d = DW'($urandom);
        push(d);
        w[k] = d;
        k++;
      end
      tick();
    end
    m_ready = 1'b1;
    wait_got(base + k, 40, "toggle");
    repeat (4) tick();
    n_checks++; if (got_n !== base + k) $display("FAIL toggle_count got %0d want %0d", got_n - base, k); else n_pass++;
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (got_data[base+i] !== w[i]) $display("FAIL toggle_data%0d got %h want %h", i, got_data[base+i], w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clk_enable();
    int base;
    m_ready = 1'b0;
    base = got_n;
    push(8'hA5);
    #1;
    n_checks++; if (fifo_read !== 1'b1) $display("FAIL ce_read got %b want 1", fifo_read); else n_pass++;
    tick();
    clk_enable = 1'b0;
    #1;
    n_checks++; if (fifo_read !== 1'b0) $display("FAIL ce_read_gated got %b want 0", fifo_read); else n_pass++;
    repeat (3) begin
      tick();
      n_checks++; if (m_valid !== 1'b0) $display("FAIL ce_frozen_valid got %b want 0", m_valid); else n_pass++;
    end
    clk_enable = 1'b1;
    tick();
    n_checks++; if (m_valid !== 1'b1) $display("FAIL ce_resume_valid got %b want 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'hA5) $display("FAIL ce_resume_data got %h want a5", m_data); else n_pass++;
    m_ready    = 1'b1;
    clk_enable = 1'b0;
    repeat (3) tick();
    n_checks++; if (got_n !== base) $display("FAIL ce_no_pop got %0d want 0", got_n - base); else n_pass++;
    n_checks++; if (m_data !== 8'hA5) $display("FAIL ce_hold_data got %h want a5", m_data); else n_pass++;
    clk_enable = 1'b1;
    wait_got(base + 1, 10, "ce");
    n_checks++; if (got_data[base] !== 8'hA5) $display("FAIL ce_data got %h want a5", got_data[base]); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int base;
    logic [DW-1:0] w [0:2];
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(DW'($urandom));
    repeat (5) tick();
    n_checks++;
    if (!(m_valid === 1'b1 && fifo_read === 1'b1))
      $display("FAIL rmid_streaming got valid=%b read=%b want 1 1", m_valid, fifo_read);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (fifo_read !== 1'b0) $display("FAIL rmid_read got %b want 0", fifo_read); else n_pass++;
`ifdef FIFO_READ_STREAM_CNT_EN
    n_checks++; if (word_count !== '0) $display("FAIL rmid_word_count got %0d want 0", word_count); else n_pass++;
`endif
    wr_ptr = rd_ptr;
    repeat (2) tick();
    reset_n  = 1'b1;
    cnt_base = got_n;
    tick();
    base = got_n;
    for (int i = 0; i < 3; i++) begin
      w[i] = DW'($urandom);
      push(w[i]);
    end
    wait_got(base + 3, 20, "rmid");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_data[base+i] !== w[i]) $display("FAIL rmid_data%0d got %h want %h", i, got_data[base+i], w[i]);
      else n_pass++;
    end
    tick();
`ifdef FIFO_READ_STREAM_CNT_EN
    n_checks++;
    if (word_count !== CW'(got_n - cnt_base)) $display("FAIL rmid_count got %0d want %0d", word_count, (got_n - cnt_base) % 16);
    else n_pass++;
`endif
  endtask

`ifdef FIFO_READ_STREAM_CNT_EN
  task automatic test_wrap();
    int base;
    reset_n = 1'b0;
    wr_ptr  = rd_ptr;
    repeat (2) tick();
    reset_n  = 1'b1;
    cnt_base = got_n;
    tick();
    base    = got_n;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(DW'(i));
    wait_got(base + 17, 40, "wrap");
    tick();
    n_checks++; if (word_count !== CW'(1)) $display("FAIL wrap_word_count got %0d want 1", word_count); else n_pass++;
  endtask
`endif

  task automatic test_protocol();
    n_checks++; if (viol_rd !== 0) $display("FAIL proto_read_when_empty got %0d want 0", viol_rd); else n_pass++;
    n_checks++; if (viol_stable !== 0) $display("FAIL proto_stable got %0d want 0", viol_stable); else n_pass++;
    n_checks++; if (viol_over !== 0) $display("FAIL proto_overflow got %0d want 0", viol_over); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_clk_enable();
    test_reset_mid();
`ifdef FIFO_READ_STREAM_CNT_EN
    test_wrap();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
